crypto_job_arbiter: RTL and testbench

Shares one crypto core between NUM_REQ requesters (CPU, DMA, ...) using round-robin arbitration. Drives the core's bgn and cript_or_decript inputs and waits for the core's end-of-job pulse (its FIN strobe). Sits between the requesters' job interfaces and the crypto core.

---
 rtl/crypto_job_arbiter.sv | 175 +++++++++++++++++
 tb/tb_crypto_job_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_job_arbiter.sv
// Round-robin arbiter sharing one crypto core between NUM_REQ requesters.
// Optional watchdog/abort path enabled by defining CRYPTO_ARB_TIMEOUT_EN.
module crypto_job_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_mode,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   core_bgn,
    output logic [1:0]             core_mode,
    input  logic                   core_fin,
    output logic                   core_rst_n,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [CNT_W-1:0]       jobs_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("crypto_job_arbiter: unsupported parameter set");
    end

`ifdef CRYPTO_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_FIN, S_COMPLETE, S_REJECT, S_ABORT
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    // Abort lands exactly TIMEOUT_CYCLES cycles after the LAUNCH cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES - 2 : 0);

    logic [WD_W-1:0] r_wdog;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_FIN, S_COMPLETE, S_REJECT
    } state_t;
`endif

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;
    logic                 r_core_bgn;
    logic [1:0]           r_core_mode;
    logic                 r_core_rst_n;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_err;
    logic [CNT_W-1:0]     r_jobs_done;

    logic                 w_found;
    logic [PTR_W-1:0]     w_sel;
    logic [NUM_REQ-1:0]   w_sel_oh;
    logic [1:0]           w_sel_mode;
    logic                 w_mode_ok;

    // Lowest requester overall is the wrap-around fallback; lowest above the pointer overrides it.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_oh   = '0;
        w_sel_mode = 2'b00;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_found    = 1'b1;
                w_sel      = PTR_W'(i);
                w_sel_oh   = NUM_REQ'(1) << i;
                w_sel_mode = req_mode[2*i +: 2];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(r_ptr))) begin
                w_sel      = PTR_W'(i);
                w_sel_oh   = NUM_REQ'(1) << i;
                w_sel_mode = req_mode[2*i +: 2];
            end
        end
    end

    assign w_mode_ok = (w_sel_mode == 2'b01) || (w_sel_mode == 2'b10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= PTR_W'(NUM_REQ - 1);
            r_owner      <= '0;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_core_bgn   <= 1'b0;
            r_core_mode  <= 2'b00;
            r_core_rst_n <= 1'b1;
            r_done       <= '0;
            r_err        <= '0;
            r_jobs_done  <= '0;
`ifdef CRYPTO_ARB_TIMEOUT_EN
            r_wdog       <= '0;
`endif
        end else begin
            r_core_bgn   <= 1'b0;
            r_core_rst_n <= 1'b1;
            r_done       <= '0;
            r_err        <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_sel_oh;
                        r_owner     <= w_sel;
                        r_core_mode <= w_sel_mode;
                        r_busy      <= 1'b1;
                        if (w_mode_ok) begin
                            r_state    <= S_LAUNCH;
                            r_core_bgn <= 1'b1;
                        end else begin
                            // Invalid modes would stall the core, so they never reach it.
                            r_state <= S_REJECT;
                            r_err   <= w_sel_oh;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT_FIN;
`ifdef CRYPTO_ARB_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                end
                S_WAIT_FIN: begin
                    if (core_fin) begin
                        r_state     <= S_COMPLETE;
                        r_done      <= r_grant;
                        r_jobs_done <= r_jobs_done + CNT_W'(1);
                    end
`ifdef CRYPTO_ARB_TIMEOUT_EN
                    else if (r_wdog == WD_LAST) begin
                        r_state      <= S_ABORT;
                        r_core_rst_n <= 1'b0;
                        r_err        <= r_grant;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
`endif
                end
`ifdef CRYPTO_ARB_TIMEOUT_EN
                S_COMPLETE, S_REJECT, S_ABORT: begin
`else
                S_COMPLETE, S_REJECT: begin
`endif
                    r_ptr       <= r_owner;
                    r_grant     <= '0;
                    r_busy      <= 1'b0;
                    r_core_mode <= 2'b00;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign core_bgn   = r_core_bgn;
    assign core_mode  = r_core_mode;
    assign core_rst_n = r_core_rst_n;
    assign done       = r_done;
    assign err        = r_err;
    assign jobs_done  = r_jobs_done;

endmodule

// File: tb/tb_crypto_job_arbiter.sv
// Directed bench for crypto_job_arbiter with a scoreboard of expected grants/modes.
module tb_crypto_job_arbiter;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_mode;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 core_bgn;
    logic [1:0]           core_mode;
    logic                 core_fin;
    logic                 core_rst_n;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic [CNT_W-1:0]     jobs_done;

    typedef struct packed {
        logic [7:0]         owner;
        logic [NUM_REQ-1:0] grant;
        logic [1:0]         mode;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  m_ptr;
    int  m_jobs;

    crypto_job_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .TIMEOUT_CYCLES(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_mode   (req_mode),
        .grant      (grant),
        .busy       (busy),
        .core_bgn   (core_bgn),
        .core_mode  (core_mode),
        .core_fin   (core_fin),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] r);
        logic [NUM_REQ-1:0] t;
        for (int k = 1; k <= NUM_REQ; k++) begin
            t = r >> ((ptr + k) % NUM_REQ);
            if (t[0]) return (ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic push_exp(input int owner);
        sb_t                  e;
        logic [2*NUM_REQ-1:0] m;
        m       = req_mode >> (2 * owner);
        e.owner = 8'(owner);
        e.grant = NUM_REQ'(1) << owner;
        e.mode  = m[1:0];
        sbq.push_back(e);
    endtask

    task automatic wait_bgn(output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (core_bgn === 1'b1) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
        end
        chk("bgn_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_job(input int fin_delay, input int exp_lat, input bit drop_req);
        bit  seen;
        int  lat;
        bit  bad;
        sb_t e;
        wait_bgn(seen, lat);
        chk("sb_pending", 32'(sbq.size()), 32'd1);
        if (!seen || sbq.size() == 0) return;
        e = sbq.pop_front();
        if (exp_lat > 0) chk("bgn_latency", 32'(lat), 32'(exp_lat));
        chk("launch_grant", 32'(grant), 32'(e.grant));
        chk("launch_mode", 32'(core_mode), 32'(e.mode));
        chk("launch_busy", 32'(busy), 32'd1);
        if (drop_req) begin
            req      = '0;
            req_mode = ~req_mode;
        end
        bad = 1'b0;
        repeat (fin_delay) begin
            @(negedge clk);
            if (core_bgn !== 1'b0 || grant !== e.grant || core_mode !== e.mode ||
                done !== '0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("wait_hold", 32'(bad), 32'd0);
        core_fin = 1'b1;
        @(negedge clk);
        core_fin = 1'b0;
        m_jobs++;
        m_ptr = int'(e.owner);
        chk("done", 32'(done), 32'(e.grant));
        chk("err_quiet", 32'(err), 32'd0);
        chk("jobs_done", 32'(jobs_done), 32'(m_jobs));
        @(negedge clk);
        chk("done_once", 32'(done), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit  seen;
        int  lat;
        bit  bad;
        sb_t e;

        rst      = 1'b0;
        req      = '0;
        req_mode = '0;
        core_fin = 1'b0;
        m_ptr    = NUM_REQ - 1;
        m_jobs   = 0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bgn", 32'(core_bgn), 32'd0);
        chk("rst_mode", 32'(core_mode), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_jobs", 32'(jobs_done), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // single job, 40-cycle core
        req_mode = 4'b0001;
        req      = 2'b01;
        push_exp(rr_pick(m_ptr, req));
        run_job(40, 1, 1'b0);
        req = '0;
        @(negedge clk);

        // contention from a fresh reset: grants alternate 0,1,0,1
        rst = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        m_ptr  = NUM_REQ - 1;
        m_jobs = 0;
        @(negedge clk);
        req_mode = 4'b1001;
        req      = 2'b11;
        for (int j = 0; j < 4; j++) begin
            push_exp(rr_pick(m_ptr, req));
            run_job(10 + j, 1, 1'b0);
        end
        chk("jobs_after_four", 32'(jobs_done), 32'd4);
        req = '0;
        @(negedge clk);

        // invalid mode on requester 0 is rejected, requester 1 then served
        req_mode = 4'b1011;
        req      = 2'b01;
        push_exp(rr_pick(m_ptr, req));
        seen = 1'b0;
        bad  = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (core_bgn !== 1'b0) bad = 1'b1;
            if (err !== '0) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
        end
        chk("rej_seen", 32'(seen), 32'd1);
        e = sbq.pop_front();
        chk("rej_err", 32'(err), 32'(e.grant));
        chk("rej_latency", 32'(lat), 32'd1);
        chk("rej_no_bgn", 32'(bad), 32'd0);
        chk("rej_done", 32'(done), 32'd0);
        chk("rej_jobs", 32'(jobs_done), 32'(m_jobs));
        m_ptr = int'(e.owner);
        req   = '0;
        @(negedge clk);
        chk("rej_err_once", 32'(err), 32'd0);
        chk("rej_idle_busy", 32'(busy), 32'd0);
        chk("rej_core_bgn", 32'(core_bgn), 32'd0);
        req = 2'b10;
        push_exp(rr_pick(m_ptr, req));
        run_job(12, 1, 1'b0);
        req = '0;
        @(negedge clk);

        // reset mid-job: pointer set to 0 by a completed job, then requester 1 aborted by reset
        req_mode = 4'b1001;
        req      = 2'b01;
        push_exp(rr_pick(m_ptr, req));
        run_job(6, 1, 1'b0);
        req = 2'b10;
        push_exp(rr_pick(m_ptr, req));
        wait_bgn(seen, lat);
        e = sbq.pop_front();
        chk("mid_grant", 32'(grant), 32'(e.grant));
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mode", 32'(core_mode), 32'd0);
        chk("mid_rst_jobs", 32'(jobs_done), 32'd0);
        chk("mid_rst_core_rst_n", 32'(core_rst_n), 32'd1);
        req    = '0;
        m_ptr  = NUM_REQ - 1;
        m_jobs = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== '0 || err !== '0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);
        req = 2'b11;
        push_exp(rr_pick(m_ptr, req));
        run_job(8, 1, 1'b0);
        req = '0;
        @(negedge clk);

        // spurious core_fin in IDLE, then req dropped during WAIT_FIN
        core_fin = 1'b1;
        @(negedge clk);
        core_fin = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== '0 || busy !== 1'b0 || core_bgn !== 1'b0) bad = 1'b1;
        end
        chk("idle_fin_ignored", 32'(bad), 32'd0);
        chk("idle_fin_jobs", 32'(jobs_done), 32'(m_jobs));
        req_mode = 4'b1001;
        req      = 2'b10;
        push_exp(rr_pick(m_ptr, req));
        run_job(15, 1, 1'b1);
        req = '0;

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
